mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one WIDTH-bit output channel among 4 requesters.
//  Drives the 2-bit select of a bank of gate-level MUX4_1 cells (one per data bit).
//  Handshakes each transfer with the downstream consumer (valid/ready).
//  Bounds each grant to MAX_HOLD transfers, for fairness.
// PARAMETERS
//  WIDTH     8   data width per requester; equals the number of MUX4_1 instances
//  MAX_HOLD  4   max transfers per grant before forced rotation; legal range >=1
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  req        in   4        req[i]=1: requester i has a valid word on d<i>
//  last       in   4        last[i]=1: current word of requester i ends its burst
//  d0..d3     in   WIDTH    requester data words
//  out_ready  in   1        consumer accepts out_data this cycle
//  out_valid  out  1        out_data valid
//  out_data   out  WIDTH    muxed data = d[sel]
//  sel        out  2        registered select index of the granted requester
//  gnt        out  4        registered one-hot grant; requester i advances on req[i]&gnt[i]&out_ready
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, gnt=4'b0000, sel=2'd0, ptr=2'd0, hold_cnt=0, out_valid=0.
//   - In-flight word is dropped and not counted.
//  States: IDLE, BUSY.
//  Pick function (shared by both states):
//   - Returns the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  IDLE:
//   - If req!=0: next edge gnt=onehot(pick), sel=pick, hold_cnt=0, state=BUSY.
//   - Latency req->gnt is 1 cycle. Otherwise stay IDLE; sel holds.
//  BUSY:
//   - out_valid = req[sel] (combinational). out_data = d[sel] via the MUX4_1 bank (combinational).
//   - xfer = out_valid & out_ready. On xfer: hold_cnt++.
//   - Release occurs when any of the following holds:
//     (a) xfer & last[sel]
//     (b) xfer & hold_cnt==MAX_HOLD-1
//     (c) req[sel]==0 (withdrawal; no transfer is counted)
//   - On release, same edge:
//     - ptr = sel+1 mod 4.
//     - Re-pick from the current req using the new ptr. The previous owner has lowest priority but may win if alone.
//     - If a winner exists: load gnt/sel, hold_cnt=0, stay BUSY (zero-bubble handoff). Else state=IDLE, gnt=0.
//   - out_valid & !out_ready: sel, gnt, hold_cnt and ptr are all held. The requester must hold d and req stable.
//  Simultaneous events:
//   - last and hold-limit on the same xfer: a single release.
//   - A new req arriving during BUSY is considered only at the next release.
//  Width and range:
//   - hold_cnt is clog2(MAX_HOLD)+1 bits and never exceeds MAX_HOLD-1.
//   - With MAX_HOLD=1, every xfer releases.
//  Invariants:
//   - gnt is one-hot or zero.
//   - gnt==onehot(sel) in BUSY.
//   - out_valid==0 in IDLE and during reset.
// STRUCTURE
//  Shared defines file mux4_arb_defs.vh:
//   - ST_IDLE=1'b0, ST_BUSY=1'b1, NREQ=4, SEL_W=2.
//  Sub-module rr_pick4 (combinational):
//   - Inputs req[3:0], ptr[1:0]. Outputs any, idx[1:0].
//   - Instantiated once, shared by the IDLE and release paths.
//  Datapath: generate loop of WIDTH MUX4_1 instances, S=sel, D0..D3=d0[k]..d3[k].
//  Top level: state register, ptr, hold_cnt and gnt/sel registers. All flops use async rst.
// TESTING
//  1. Reset then req=0001, d0=8'hA5, out_ready=1
//     -> gnt=0001 and sel=0 one cycle later; out_data=A5 with out_valid=1.
//  2. req=1111, last=0, out_ready=1, MAX_HOLD=4
//     -> grants rotate 0,1,2,3,0; 4 xfers each; no idle cycle between grants.
//  3. Grant on req 2, out_ready=0 for 3 cycles
//     -> out_valid=1; sel, gnt and hold_cnt stable; xfer count unchanged; resumes when ready=1.
//  4. Grant on req 1, last[1]=1 on first xfer, req=0110
//     -> next edge gnt=0100 (req 2), ptr=2.
//  5. Grant on req 3, req[3] drops with others at 0
//     -> next edge IDLE, gnt=0, out_valid=0, ptr=0.
//  6. rst asserted mid-BUSY, between clock edges
//     -> gnt=0, out_valid=0 immediately; after release, req=0100 gives gnt=0100 one cycle later.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// Gate-level 4:1 single-bit mux cell.
module MUX4_1 (
    input  logic [1:0] S,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    output logic       Y
);

    assign Y = (~S[1] & ~S[0] & D0)
             | (~S[1] &  S[0] & D1)
             | ( S[1] & ~S[0] & D2)
             | ( S[1] &  S[0] & D3);

endmodule

// File: rtl/mux4_rr_arbiter_pick.sv
// Round-robin pick: first asserted request scanning from ptr upward, mod 4.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [SEL_W-1:0]  w_off;

    assign w_dbl = {req, req};
    assign w_rot = w_dbl[{1'b0, ptr} +: NREQ];
    assign any   = |req;

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign idx = ptr + w_off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one output channel among 4 requesters,
// with valid/ready handshake and a per-grant transfer limit.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       gnt
);

    localparam int              HW        = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_sel;
    logic [NREQ-1:0]   r_gnt;
    logic [HW-1:0]     r_hold;

    logic              w_busy;
    logic              w_valid;
    logic              w_xfer;
    logic              w_rel;
    logic              w_load;
    logic              w_any;
    logic [SEL_W-1:0]  w_idx;
    logic [SEL_W-1:0]  w_next_ptr;
    logic [SEL_W-1:0]  w_pick_ptr;

    assign w_busy     = (r_state == ST_BUSY);
    assign w_valid    = w_busy & req[r_sel];
    assign w_xfer     = w_valid & out_ready;
    assign w_rel      = w_busy & (~req[r_sel]
                      | (w_xfer & (last[r_sel] | (r_hold == HOLD_LAST))));
    assign w_next_ptr = r_sel + 2'd1;
    // Release re-picks with the rotated pointer in the same cycle.
    assign w_pick_ptr = w_rel ? w_next_ptr : r_ptr;
    assign w_load     = (~w_busy | w_rel) & w_any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (w_pick_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: if (w_any) w_state_nx = ST_BUSY;
            ST_BUSY: if (w_rel && !w_any) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = w_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_sel  <= '0;
            r_gnt  <= '0;
            r_hold <= '0;
        end else begin
            if (w_rel) r_ptr <= w_next_ptr;
            if (w_load) begin
                r_sel  <= w_idx;
                r_gnt  <= onehot4(w_idx);
                r_hold <= '0;
            end else if (w_rel) begin
                r_gnt  <= '0;
                r_hold <= '0;
            end else if (w_xfer) begin
                r_hold <= r_hold + HW'(1);
            end
        end
    end

    assign sel = r_sel;
    assign gnt = r_gnt;

    for (genvar k = 0; k < WIDTH; k++) begin : g_mux
        MUX4_1 u_mux (
            .S  (r_sel),
            .D0 (d0[k]),
            .D1 (d1[k]),
            .D2 (d2[k]),
            .D3 (d3[k]),
            .Y  (out_data[k])
        );
    end

endmodule
